// File: rtl/nibble_deserializer_pkg.sv
// ============================================================================
// Module  : nibble_deserializer_pkg
// Brief   : Shared state encoding, default width and counter sizing helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nibble_deserializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam int DEFAULT_DATA_W = 4;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_deserializer_out_reg.sv
// ============================================================================
// Module  : nibble_out_reg
// Brief   : Single-entry valid/ready holding register; flags loads it drops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_out_reg #(
    parameter int DATA_W = 4
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              En_SI,
    input  logic              Load_SI,
    input  logic [DATA_W-1:0] Load_Data_DI,
    input  logic              Ready_DI,
    output logic [DATA_W-1:0] Data_DO,
    output logic              Valid_DO,
    output logic              Drop_SO
);

    logic w_accept;
    logic w_free;
    logic w_load_ok;

    // A consume in the same cycle frees the slot, so load and accept can coincide.
    assign w_accept  = Valid_DO & Ready_DI;
    assign w_free    = ~Valid_DO | Ready_DI;
    assign w_load_ok = Load_SI & w_free;
    assign Drop_SO   = En_SI & Load_SI & ~w_free;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            Data_DO  <= '0;
            Valid_DO <= 1'b0;
        end else if (En_SI) begin
            if (w_load_ok) begin
                Data_DO  <= Load_Data_DI;
                Valid_DO <= 1'b1;
            end else if (w_accept) begin
                Valid_DO <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nibble_deserializer.sv
// ============================================================================
// Module  : nibble_deserializer
// Brief   : Framed serial-to-parallel converter with framing/overrun flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_deserializer
    import nibble_deserializer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              En_SI,
    input  logic              Ser_DI,
    input  logic              Ser_Valid_SI,
    output logic [DATA_W-1:0] Data_DO,
    output logic              Valid_DO,
    input  logic              Ready_DI,
    output logic              FrameErr_DO,
    output logic              Overrun_DO,
    input  logic              ClrErr_SI
);

    localparam int         CNT_W  = cnt_width(DATA_W);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_DATA = ST_DATA;
    localparam logic [1:0] S_STOP = ST_STOP;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_frame_err;
    logic              r_overrun;

    logic w_take;
    logic w_load;
    logic w_bad_stop;
    logic w_last;
    logic w_drop;

    assign w_take     = En_SI & Ser_Valid_SI;
    assign w_load     = w_take & (r_state == S_STOP) & Ser_DI;
    assign w_bad_stop = w_take & (r_state == S_STOP) & ~Ser_DI;
    assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_take) begin
            case (r_state)
                S_IDLE: begin
                    if (!Ser_DI) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    // LSB arrives first, so new bits enter at the top and drift down.
                    r_shift <= (r_shift >> 1) | (DATA_W'(Ser_DI) << (DATA_W - 1));
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (En_SI) begin
            r_frame_err <= w_bad_stop | (r_frame_err & ~ClrErr_SI);
            r_overrun   <= w_drop     | (r_overrun   & ~ClrErr_SI);
        end
    end

    nibble_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .Clk_CI       (Clk_CI),
        .Rst_RBI      (Rst_RBI),
        .En_SI        (En_SI),
        .Load_SI      (w_load),
        .Load_Data_DI (r_shift),
        .Ready_DI     (Ready_DI),
        .Data_DO      (Data_DO),
        .Valid_DO     (Valid_DO),
        .Drop_SO      (w_drop)
    );

    assign FrameErr_DO = r_frame_err;
    assign Overrun_DO  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_nibble_deserializer.sv
// ============================================================================
// Module  : tb_nibble_deserializer
// Brief   : Scoreboard bench: frame driver plus word-level reference monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nibble_deserializer;

    logic       Clk_CI       = 1'b0;
    logic       Rst_RBI      = 1'b0;
    logic       En_SI        = 1'b0;
    logic       Ser_DI       = 1'b1;
    logic       Ser_Valid_SI = 1'b0;
    logic       Ready_DI     = 1'b0;
    logic       ClrErr_SI    = 1'b0;
    logic [3:0] Data_DO;
    logic       Valid_DO;
    logic       FrameErr_DO;
    logic       Overrun_DO;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    bit         m_ferr    = 1'b0;
    bit         m_ovr     = 1'b0;
    bit         ev_good   = 1'b0;
    bit         ev_bad    = 1'b0;
    logic [3:0] ev_data   = 4'h0;
    bit         rnd_ready = 1'b0;

    nibble_deserializer #(.DATA_W(4)) dut (
        .Clk_CI       (Clk_CI),
        .Rst_RBI      (Rst_RBI),
        .En_SI        (En_SI),
        .Ser_DI       (Ser_DI),
        .Ser_Valid_SI (Ser_Valid_SI),
        .Data_DO      (Data_DO),
        .Valid_DO     (Valid_DO),
        .Ready_DI     (Ready_DI),
        .FrameErr_DO  (FrameErr_DO),
        .Overrun_DO   (Overrun_DO),
        .ClrErr_SI    (ClrErr_SI)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Word-level reference: at most one pending word, sticky flags, set beats clear.
    always @(negedge Clk_CI) begin
        bit set_ovr;
        if (!Rst_RBI) begin
            chk("rst_valid", Valid_DO, 0);
            chk("rst_data", Data_DO, 0);
            chk("rst_ferr", FrameErr_DO, 0);
            chk("rst_ovr", Overrun_DO, 0);
            exp_q.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            chk("valid", Valid_DO, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("data", Data_DO, exp_q[0]);
            chk("ferr", FrameErr_DO, m_ferr);
            chk("ovr", Overrun_DO, m_ovr);
            if (En_SI) begin
                set_ovr = 1'b0;
                if (exp_q.size() != 0 && Ready_DI) void'(exp_q.pop_front());
                if (ev_good) begin
                    if (exp_q.size() == 0) exp_q.push_back(ev_data);
                    else                   set_ovr = 1'b1;
                end
                m_ferr = ev_bad  | (m_ferr & ~ClrErr_SI);
                m_ovr  = set_ovr | (m_ovr  & ~ClrErr_SI);
            end
        end
    end

    task automatic tick();
        if (rnd_ready) Ready_DI = 1'($urandom_range(0, 1));
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic gap(input int n, input bit rnd);
        repeat (n) begin
            En_SI        = 1'b1;
            Ser_Valid_SI = 1'b0;
            ClrErr_SI    = 1'b0;
            if (rnd) begin
                En_SI = ($urandom_range(0, 3) != 0);
                if (!En_SI) begin
                    Ser_Valid_SI = 1'($urandom_range(0, 1));
                    Ser_DI       = 1'($urandom_range(0, 1));
                end
                ClrErr_SI = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        En_SI        = 1'b1;
        Ser_Valid_SI = 1'b0;
        Ser_DI       = 1'b1;
        ClrErr_SI    = 1'b0;
    endtask

    task automatic send_bit(input bit b, input int gaps, input bit rnd);
        gap(gaps, rnd);
        Ser_Valid_SI = 1'b1;
        Ser_DI       = b;
        tick();
        Ser_Valid_SI = 1'b0;
        Ser_DI       = 1'b1;
    endtask

    task automatic send_stop(input logic [3:0] d, input bit good, input bit ready_stop, input bit clr_stop);
        En_SI        = 1'b1;
        Ser_Valid_SI = 1'b1;
        Ser_DI       = good;
        ClrErr_SI    = clr_stop;
        if (ready_stop) Ready_DI = 1'b1;
        ev_good = good;
        ev_bad  = !good;
        ev_data = d;
        tick();
        ev_good      = 1'b0;
        ev_bad       = 1'b0;
        Ser_Valid_SI = 1'b0;
        Ser_DI       = 1'b1;
        ClrErr_SI    = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input bit good, input int gaps, input bit rnd);
        send_bit(1'b0, gaps, rnd);
        for (int i = 0; i < 4; i++) send_bit(d[i], gaps, rnd);
        gap(gaps, rnd);
        send_stop(d, good, 1'b0, 1'b0);
    endtask

    task automatic clr_pulse();
        ClrErr_SI = 1'b1;
        tick();
        ClrErr_SI = 1'b0;
    endtask

    initial begin
        #1;
        chk("init_valid", Valid_DO, 0);
        repeat (3) tick();
        Rst_RBI = 1'b1;
        En_SI   = 1'b1;
        tick();

        // Basic frame with a ready sink: valid for exactly one cycle.
        Ready_DI = 1'b1;
        send_frame(4'hD, 1'b1, 0, 1'b0);
        chk("basic_data", Data_DO, 4'hD);
        chk("basic_valid", Valid_DO, 1);
        tick();
        chk("basic_valid_drop", Valid_DO, 0);

        // Gapped strobes with the enable dropped mid-frame while garbage strobes.
        send_bit(1'b0, 3, 1'b0);
        send_bit(1'b1, 3, 1'b0);
        En_SI = 1'b0; Ser_Valid_SI = 1'b1; Ser_DI = 1'b0;
        tick(); tick();
        En_SI = 1'b1; Ser_Valid_SI = 1'b0; Ser_DI = 1'b1;
        send_bit(1'b0, 3, 1'b0);
        send_bit(1'b1, 3, 1'b0);
        send_bit(1'b1, 3, 1'b0);
        gap(3, 1'b0);
        send_stop(4'hD, 1'b1, 1'b0, 1'b0);
        chk("gapped_data", Data_DO, 4'hD);
        tick();

        // Backpressure: second word is dropped and flagged.
        Ready_DI = 1'b0;
        send_frame(4'h3, 1'b1, 0, 1'b0);
        send_frame(4'hA, 1'b1, 1, 1'b0);
        tick();
        chk("bp_data", Data_DO, 4'h3);
        chk("bp_ovr", Overrun_DO, 1);
        Ready_DI = 1'b1;
        tick();
        chk("bp_accept", Valid_DO, 0);
        clr_pulse();
        chk("bp_clr", Overrun_DO, 0);

        // Accept and load in the same cycle is not an overrun.
        Ready_DI = 1'b0;
        send_frame(4'h1, 1'b1, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i < 3, 0, 1'b0);
        send_stop(4'h7, 1'b1, 1'b1, 1'b0);
        chk("sim_data", Data_DO, 4'h7);
        chk("sim_valid", Valid_DO, 1);
        chk("sim_ovr", Overrun_DO, 0);
        tick();

        // Framing error, clear, then set-beats-clear, then immediate next frame.
        send_frame(4'hF, 1'b0, 0, 1'b0);
        chk("ferr_set", FrameErr_DO, 1);
        chk("ferr_novalid", Valid_DO, 0);
        clr_pulse();
        chk("ferr_clr", FrameErr_DO, 0);
        send_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0);
        send_stop(4'hF, 1'b0, 1'b0, 1'b1);
        chk("ferr_priority", FrameErr_DO, 1);
        send_frame(4'h6, 1'b1, 0, 1'b0);
        chk("after_bad_data", Data_DO, 4'h6);
        tick();
        clr_pulse();

        // Reset mid-frame while holding a word with both flags set.
        Ready_DI = 1'b0;
        send_frame(4'h9, 1'b1, 0, 1'b0);
        send_frame(4'h2, 1'b1, 0, 1'b0);
        send_frame(4'hC, 1'b0, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        Rst_RBI = 1'b0;
        #1;
        chk("midrst_valid", Valid_DO, 0);
        chk("midrst_data", Data_DO, 0);
        chk("midrst_ferr", FrameErr_DO, 0);
        chk("midrst_ovr", Overrun_DO, 0);
        tick(); tick();
        Rst_RBI  = 1'b1;
        Ready_DI = 1'b1;
        tick();
        send_frame(4'h5, 1'b1, 0, 1'b0);
        chk("postrst_data", Data_DO, 4'h5);
        chk("postrst_valid", Valid_DO, 1);
        tick();

        // Randomized frames, idle bits, gaps, enable drops and backpressure.
        rnd_ready = 1'b1;
        repeat (80) begin
            repeat ($urandom_range(0, 2)) send_bit(1'b1, $urandom_range(0, 2), 1'b1);
            send_frame(4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0,
                       $urandom_range(0, 3), 1'b1);
        end

        rnd_ready = 1'b0;
        Ready_DI  = 1'b1;
        En_SI     = 1'b1;
        repeat (3) tick();
        chk("drain_valid", Valid_DO, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_deserializer.md
Name: nibble_deserializer

Overview:
- Upstream stage of the registered 4-input parity (XOR) stage.
- Collects framed serial bits into a DATA_W-bit word and presents it with a valid/ready handshake; the parity stage consumes the word on its Data_DI bus.
- Detects framing errors (bad stop bit) and overrun (new word completes while the previous word is still unconsumed).

Parameters:
- DATA_W, 4, payload bits per frame; must be >= 1; output word width.

Ports:
- Clk_CI  in  1  clock; all state updates on rising edge.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- En_SI  in  1  clock enable; when 0, all state and outputs hold and Ser_Valid_SI is ignored.
- Ser_DI  in  1  serial data bit.
- Ser_Valid_SI  in  1  Ser_DI is meaningful this cycle (one bit per strobe).
- Data_DO  out  DATA_W  deserialized word, LSB received first.
- Valid_DO  out  1  Data_DO holds an unconsumed word.
- Ready_DI  in  1  downstream accepts Data_DO when Valid_DO && Ready_DI.
- FrameErr_DO  out  1  sticky: a stop bit sampled as 0.
- Overrun_DO  out  1  sticky: a completed frame was dropped.
- ClrErr_SI  in  1  synchronous clear of both sticky flags (qualified by En_SI).

Behaviour:
- Reset values: Data_DO = 0, Valid_DO = 0, FrameErr_DO = 0, Overrun_DO = 0, FSM = IDLE, bit counter = 0, shift register = 0.
- Reset asserted mid-frame aborts the frame with no flag set. The partial word is lost.
- A bit is "taken" only in a cycle with En_SI && Ser_Valid_SI.
- Frame format: start bit 0, then DATA_W payload bits LSB first, then stop bit 1.
- FSM IDLE:
  - Taken bit 0 -> DATA, counter = 0.
  - Taken bit 1 -> stay in IDLE (line idle).
- FSM DATA:
  - Each taken bit shifts in at the MSB end (shift right), counter increments.
  - After the DATA_W-th taken bit -> STOP.
- FSM STOP, taken bit = 1 (good frame) -> IDLE, and:
  - If the output register is free this cycle, load the shift register into Data_DO; Valid_DO = 1 from the next cycle.
  - Free means Valid_DO == 0, or Valid_DO && Ready_DI in the same cycle (simultaneous consume and load: no overrun).
  - Otherwise drop the new word, keep Data_DO and Valid_DO unchanged, and set Overrun_DO.
- FSM STOP, taken bit = 0 (bad stop) -> IDLE, word discarded, FrameErr_DO set.
  - The bad stop bit is not reinterpreted as a start bit.
- Latency: Valid_DO rises one cycle after the cycle in which the good stop bit is taken.
- Handshake:
  - Valid_DO && Ready_DI && En_SI -> Valid_DO = 0 next cycle unless a load occurs in the same cycle.
  - Data_DO is stable while Valid_DO = 1 and the word is unaccepted.
  - Valid_DO never drops without acceptance.
- Cycles without Ser_Valid_SI are idle gaps and are allowed in any state, with unbounded length.
- Sticky flags:
  - Set has priority over ClrErr_SI in the same cycle.
  - Flags do not affect the data path.
- En_SI = 0: no transitions, no handshake completion, no flag updates.

Decomposition:
- Shared package contains:
  - the FSM state enum (IDLE, DATA, STOP);
  - the default payload width constant (4);
  - the bit-counter width function, $clog2(DATA_W+1).
- Natural sub-module: nibble_out_reg, the single-entry valid/ready holding register with load, accept and drop-on-full indication.
  - Its drop indication drives Overrun_DO.
- The FSM and shift register stay in the top module.

Test Plan:
- Basic frame: bits 0,1,0,1,1,1 (start, payload 1011 LSB-first = 4'hD, stop) with Ready_DI = 1 -> Data_DO = 4'hD, Valid_DO high exactly one cycle, flags 0.
- Gapped strobes: same frame with Ser_Valid_SI low 3 cycles between every bit, and En_SI low 2 cycles mid-frame -> identical result, 4'hD.
- Backpressure and overrun:
  - Ready_DI = 0; send 4'h3 then 4'hA -> Data_DO stays 4'h3, Overrun_DO = 1.
  - Raise Ready_DI -> accepts 4'h3, Valid_DO = 0.
- Simultaneous accept and load: Valid_DO = 1 holding 4'h1; Ready_DI = 1 in the stop-bit cycle of 4'h7 -> next cycle Data_DO = 4'h7, Valid_DO = 1, Overrun_DO = 0.
- Framing error: payload 4'hF with stop bit 0 -> FrameErr_DO = 1, Valid_DO stays 0; ClrErr_SI pulse -> FrameErr_DO = 0.
- Reset mid-frame: drop Rst_RBI after 2 payload bits -> outputs 0 immediately; a following full frame 4'h5 is received correctly.
